// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock first-word fall-through FIFO with DEPTH = 2**DEPTH_BITS
// entries of SIZE bits each. The head entry is always visible on q while the
// FIFO is non-empty. Writes into a full FIFO are accepted only when a read is
// accepted in the same cycle. A read of an empty FIFO is never bypassed by a
// write in the same cycle. Overflow and underflow events are latched in
// sticky flags until clear or reset.
//
// Ports
//   clock      in   1             rising-edge clock
//   reset_n    in   1             asynchronous active-low reset
//   clear      in   1             synchronous flush (pointers, count, flags)
//   d          in   SIZE          write data
//   write      in   1             write request
//   read       in   1             read request (pops head)
//   q          out  SIZE          head entry (fall-through)
//   empty      out  1             count == 0
//   full       out  1             count == DEPTH
//   count      out  DEPTH_BITS+1  number of stored entries
//   overflow   out  1             sticky: write rejected while full
//   underflow  out  1             sticky: read rejected while empty
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int SIZE       = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic [SIZE-1:0]       d,
    input  logic                  write,
    input  logic                  read,
    output logic [SIZE-1:0]       q,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_BITS:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int CNT_W = DEPTH_BITS + 1;

    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);

    logic [SIZE-1:0]       mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty_w;
    logic full_w;
    logic wr_accept;
    logic rd_accept;

    // Status is decoded from the registered count only, so it changes the
    // cycle after the edge that caused it.
    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_FULL);

    // A full FIFO can still take a write when the head leaves in the same
    // cycle; an empty FIFO cannot satisfy a read from the incoming word.
    assign rd_accept = read  && !empty_w;
    assign wr_accept = write && (!full_w || read);

    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (which would infer a latch).
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clear) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_accept) rd_ptr_d = rd_ptr_q + PTR_ONE;

            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            if (write && full_w && !read) overflow_d  = 1'b1;
            if (read && empty_w)          underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: non-blocking assignments for all state so every register
            // samples the pre-edge values regardless of statement order.
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: the storage array is reset on purpose: q is visible while empty
    // and must read as zero, not X, straight out of reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_accept && !clear) begin
            mem_q[wr_ptr_q] <= d;
        end
    end

    assign q         = mem_q[rd_ptr_q];
    assign empty     = empty_w;
    assign full      = full_w;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo
//
// Self-checking bench for sync_fifo (SIZE=8, DEPTH_BITS=2). A table of
// hand-derived vectors covers fill/drain, overflow, simultaneous access at
// full and at empty, and clear. Hand-written sequences cover wrap-around and
// asynchronous reset. A queue-based scoreboard checks a random traffic phase.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge, or on the falling edge for the pre-edge head value.
// ----------------------------------------------------------------------------
module tb_sync_fifo;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       clear;
    logic [7:0] d;
    logic       write;
    logic       read;
    logic [7:0] q;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    sync_fifo #(.SIZE(8), .DEPTH_BITS(2)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .d         (d),
        .write     (write),
        .read      (read),
        .q         (q),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input int exp_cnt, input logic exp_ovf,
                                input logic exp_unf);
        check({tag, " count"},     32'(count),     32'(exp_cnt));
        check({tag, " empty"},     32'(empty),     32'(exp_cnt == 0));
        check({tag, " full"},      32'(full),      32'(exp_cnt == 4));
        check({tag, " overflow"},  32'(overflow),  32'(exp_ovf));
        check({tag, " underflow"}, 32'(underflow), 32'(exp_unf));
    endtask

    task automatic drive(input logic w, input logic r, input logic clr, input logic [7:0] din);
        @(negedge clock);
        write = w;
        read  = r;
        clear = clr;
        d     = din;
    endtask

    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic       w;
        logic       r;
        logic       clr;
        logic [7:0] din;
        int         cnt;
        logic       ovf;
        logic       unf;
        logic       chk_q;
        logic [7:0] q;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic w, input logic r, input logic clr,
                                input logic [7:0] din, input int cnt, input logic ovf,
                                input logic unf, input logic chk_q, input logic [7:0] qv);
        vec_t v;
        v.w = w; v.r = r; v.clr = clr; v.din = din; v.cnt = cnt;
        v.ovf = ovf; v.unf = unf; v.chk_q = chk_q; v.q = qv;
        vecs.push_back(v);
    endfunction

    logic [7:0] sb[$];
    logic [7:0] exp_v;
    int         m_ovf;
    int         m_unf;

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        write   = 1'b0;
        read    = 1'b0;
        d       = '0;

        //     w  r  c  din    cnt ovf unf chk  q
        add(1, 0, 0, 8'h11, 1, 0, 0, 1, 8'h11);   // fill
        add(1, 0, 0, 8'h22, 2, 0, 0, 1, 8'h11);
        add(1, 0, 0, 8'h33, 3, 0, 0, 1, 8'h11);
        add(1, 0, 0, 8'h44, 4, 0, 0, 1, 8'h11);
        add(1, 0, 0, 8'h55, 4, 1, 0, 1, 8'h11);   // overflow, 0x55 dropped
        add(0, 1, 0, 8'h00, 3, 1, 0, 1, 8'h22);   // drain
        add(0, 1, 0, 8'h00, 2, 1, 0, 1, 8'h33);
        add(0, 1, 0, 8'h00, 1, 1, 0, 1, 8'h44);
        add(0, 1, 0, 8'h00, 0, 1, 0, 0, 8'h00);
        add(0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00);   // clear drops overflow
        add(1, 0, 0, 8'h11, 1, 0, 0, 1, 8'h11);   // refill
        add(1, 0, 0, 8'h22, 2, 0, 0, 1, 8'h11);
        add(1, 0, 0, 8'h33, 3, 0, 0, 1, 8'h11);
        add(1, 0, 0, 8'h44, 4, 0, 0, 1, 8'h11);
        add(1, 1, 0, 8'h66, 4, 0, 0, 1, 8'h22);   // simultaneous at full
        add(0, 1, 0, 8'h00, 3, 0, 0, 1, 8'h33);
        add(0, 1, 0, 8'h00, 2, 0, 0, 1, 8'h44);
        add(0, 1, 0, 8'h00, 1, 0, 0, 1, 8'h66);
        add(0, 1, 0, 8'h00, 0, 0, 0, 0, 8'h00);
        add(1, 1, 0, 8'hA5, 1, 0, 1, 1, 8'hA5);   // simultaneous at empty
        add(0, 1, 0, 8'h00, 0, 0, 1, 0, 8'h00);
        add(0, 0, 1, 8'h00, 0, 0, 0, 0, 8'h00);   // clear drops underflow

        #12;
        check_status("reset", 0, 1'b0, 1'b0);
        check("reset q", 32'(q), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        foreach (vecs[i]) begin
            drive(vecs[i].w, vecs[i].r, vecs[i].clr, vecs[i].din);
            settle();
            check_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
            if (vecs[i].chk_q) check($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].q));
        end

        // ---------------- wrap-around, staggered pairs ----------------
        for (int i = 0; i <= 10; i++) begin
            drive(i < 10, i > 0, 1'b0, 8'(i));
            if (i > 0) begin
                exp_v = sb.pop_front();
                check($sformatf("wrap q%0d", i - 1), 32'(q), 32'(exp_v));
            end
            if (i < 10) sb.push_back(8'(i));
            settle();
            check($sformatf("wrap cnt<=2 %0d", i), 32'(count <= 3'd2), 32'h1);
        end
        check_status("wrap end", 0, 1'b0, 1'b0);

        // ---------------- async reset mid-operation ----------------
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
            settle();
        end
        check("pre-reset count", 32'(count), 32'd3);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        check_status("async reset", 0, 1'b0, 1'b0);
        check("async reset q", 32'(q), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h3C);
        settle();
        check_status("post-reset write", 1, 1'b0, 1'b0);
        check("post-reset q", 32'(q), 32'h3C);
        drive(0, 1, 0, 8'h00);
        settle();

        // ---------------- clear overrides write ----------------
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h70 + 8'(i));
            settle();
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00);
        settle();
        check_status("pre-clear", 3, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'hEE);
        settle();
        check_status("clear+write", 0, 1'b0, 1'b0);

        // ---------------- random traffic vs scoreboard ----------------
        sb.delete();
        m_ovf = 0;
        m_unf = 0;
        for (int i = 0; i < 300; i++) begin
            logic w, r, c, m_full, m_empty;
            logic [7:0] din;
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 39) == 0);
            din = 8'($urandom);
            drive(w, r, c, din);
            m_full  = (sb.size() == 4);
            m_empty = (sb.size() == 0);
            if (c) begin
                sb.delete();
                m_ovf = 0;
                m_unf = 0;
            end else begin
                if (r && !m_empty) begin
                    exp_v = sb.pop_front();
                    check($sformatf("rand q%0d", i), 32'(q), 32'(exp_v));
                end
                if (w && (!m_full || r)) sb.push_back(din);
                if (w && m_full && !r) m_ovf = 1;
                if (r && m_empty)      m_unf = 1;
            end
            settle();
            check_status($sformatf("rand%0d", i), sb.size(), 1'(m_ovf), 1'(m_unf));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter SIZE, default 8, data word width in bits.
REQ-002 Parameter DEPTH_BITS, default 2, log2 of entry count (DEPTH = 2^DEPTH_BITS = 4).
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous flush, active-high.
REQ-006 d  input  SIZE  write data.
REQ-007 write  input  1  write request; d captured when accepted.
REQ-008 read  input  1  read request; pops head entry when accepted.
REQ-009 q  output  SIZE  head (oldest) entry, first-word fall-through.
REQ-010 empty  output  1  high when count = 0.
REQ-011 full  output  1  high when count = DEPTH.
REQ-012 count  output  DEPTH_BITS+1  number of stored entries, 0..DEPTH.
REQ-013 overflow  output  1  sticky: write rejected while full.
REQ-014 underflow  output  1  sticky: read rejected while empty.

Function
REQ-015 Storage SHALL be DEPTH registers of SIZE bits, write pointer, read pointer (DEPTH_BITS each, wrap modulo DEPTH), and count register.
REQ-016 Write SHALL be accepted when write=1 and (full=0 or read=1); accepted data stored at write pointer, pointer +1.
REQ-017 Read SHALL be accepted when read=1 and empty=0; read pointer +1.
REQ-018 count SHALL be +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
REQ-019 Full with write=1 and read=1 SHALL accept both; count stays DEPTH, no overflow.
REQ-020 Empty with write=1 and read=1 SHALL accept write only (no bypass); count becomes 1, underflow sets.
REQ-021 q SHALL equal storage at read pointer whenever empty=0; q value when empty=1 is don't-care but SHALL NOT be X after reset (storage reset to 0).
REQ-022 Write data SHALL appear on q no earlier than the cycle after acceptance (minimum latency 1 cycle into empty FIFO).
REQ-023 empty, full, count SHALL be decoded from registered count, updating the cycle after the causing edge.
REQ-024 overflow SHALL set on a cycle with write=1, full=1, read=0; underflow SHALL set on read=1, empty=1; both hold until clear or reset.
REQ-025 clear=1 SHALL zero pointers, count, overflow, underflow on the next edge, overriding write and read in that cycle; storage contents need not be cleared.
REQ-026 Rejected writes and reads SHALL NOT alter storage, pointers, or count.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 without gap or duplication.

Reset
REQ-028 reset_n=0 SHALL immediately, independent of clock, force pointers=0, count=0, storage=0, overflow=0, underflow=0, hence empty=1, full=0, q=0.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries; first edge after deassertion behaves as on an empty FIFO.
REQ-030 Reset SHALL take priority over clear, write, and read.

Verification
REQ-031 Fill/drain: after reset write 0x11,0x22,0x33,0x44 -> full=1, count=4; then read x4 -> q sequence 0x11,0x22,0x33,0x44, empty=1.
REQ-032 Overflow: full with 0x11..0x44, write 0x55 read=0 -> overflow=1, count=4, subsequent reads return 0x11..0x44 (0x55 absent).
REQ-033 Simultaneous at full: full, write 0x66 with read -> pops 0x11, count=4, final contents 0x22,0x33,0x44,0x66; no overflow.
REQ-034 Simultaneous at empty: empty, write 0xA5 with read -> count=1, underflow=1, q=0xA5 next cycle.
REQ-035 Wrap-around: 10 write/read pairs of 0x00..0x09 staggered by one cycle -> every value read in order, count never exceeds 2.
REQ-036 Async reset/clear: with count=3, drop reset_n between edges -> empty=1, count=0 before next edge; repeat with clear=1 plus write=1 -> count=0, flags cleared.
